// File: rtl/tipi_pkg.sv
// Shared types and constants for the TIPI write-register / Pi shift block.
// Build option: define TIPI_WR_SYNC_EN to add a second synchronizer flop on
// every asynchronous input (cpu_we_n, pi_sclk, pi_le).
package tipi_pkg;

  localparam int TIPI_REG_W = 8;

  // Values of pi_sel
  localparam logic PI_SEL_TD = 1'b0;
  localparam logic PI_SEL_TC = 1'b1;

  // Pi-side read FSM
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } tipi_state_e;

  // Shift left by one with zero fill (MSB leaves first)
  function automatic logic [TIPI_REG_W-1:0] tipi_shl(input logic [TIPI_REG_W-1:0] d);
    return {d[TIPI_REG_W-2:0], 1'b0};
  endfunction

endpackage

// File: rtl/tipi_edge_sync.sv
// Synchronizer plus registered rise/fall detector for one asynchronous input.
// TIPI_WR_SYNC_EN selects a two-flop synchronizer, otherwise a single sampling
// flop. RST_LVL is the inactive level the chain resets to, so releasing reset
// never produces an edge pulse.
module tipi_edge_sync #(
  parameter logic RST_LVL = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_sync;
  logic r_prev;
  logic r_rise;
  logic r_fall;

`ifdef TIPI_WR_SYNC_EN
  logic r_meta;

  // First synchronizer stage (may go metastable)
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_meta <= RST_LVL;
    end else begin
      r_meta <= i_async;
    end
  end

  // Second synchronizer stage, the clean clk-domain level
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= RST_LVL;
    end else begin
      r_sync <= r_meta;
    end
  end
`else
  // Single sampling flop into the clk domain
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= RST_LVL;
    end else begin
      r_sync <= i_async;
    end
  end
`endif

  // Previous-level flop and registered one-clk edge pulses
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev <= RST_LVL;
      r_rise <= 1'b0;
      r_fall <= 1'b0;
    end else begin
      r_prev <= r_sync;
      r_rise <= r_sync & ~r_prev;
      r_fall <= ~r_sync & r_prev;
    end
  end

  assign o_level = r_sync;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/tipi_wreg_shift.sv
// TIPI CPU write registers (TD/TC) with a Pi-side serial read-out shifter.
// CPU writes are latched on the rising edge of the (synchronized) write strobe;
// the Pi loads TD or TC into a shift register and clocks it out MSB first.
// Build option: TIPI_WR_SYNC_EN (two-flop input synchronizers, one extra clk
// of latency on every strobe).
module tipi_wreg_shift
  import tipi_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  cpu_we_n,
  input  logic                  td_addr,
  input  logic                  tc_addr,
  input  logic [TIPI_REG_W-1:0] cpu_data,
  input  logic                  pi_sclk,
  input  logic                  pi_le,
  input  logic                  pi_sel,
  output logic                  pi_sdo,
  output logic [TIPI_REG_W-1:0] td_q,
  output logic [TIPI_REG_W-1:0] tc_q,
  output logic                  td_wr,
  output logic                  tc_wr
);

  logic w_we_lvl, w_we_rise, w_we_fall;
  logic w_sclk_lvl, w_sclk_rise, w_sclk_fall;
  logic w_le_lvl, w_le_rise, w_le_fall;
  logic w_unused;

  logic [TIPI_REG_W-1:0] r_hold;
  logic [TIPI_REG_W-1:0] r_td_q;
  logic [TIPI_REG_W-1:0] r_tc_q;
  logic                  r_td_wr;
  logic                  r_tc_wr;

  tipi_state_e           r_state;
  tipi_state_e           w_state_nxt;
  logic [TIPI_REG_W-1:0] r_shift;
  logic [TIPI_REG_W-1:0] w_shift_nxt;
  logic [2:0]            r_cnt;
  logic [2:0]            w_cnt_nxt;
  logic                  r_sdo;
  logic                  w_sdo_nxt;

  tipi_edge_sync #(.RST_LVL(1'b1)) u_we_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (cpu_we_n),
    .o_level (w_we_lvl),
    .o_rise  (w_we_rise),
    .o_fall  (w_we_fall)
  );

  tipi_edge_sync #(.RST_LVL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (pi_sclk),
    .o_level (w_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  tipi_edge_sync #(.RST_LVL(1'b0)) u_le_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .i_async (pi_le),
    .o_level (w_le_lvl),
    .o_rise  (w_le_rise),
    .o_fall  (w_le_fall)
  );

  // Only rising edges matter here; the remaining detector outputs are sunk
  assign w_unused = &{1'b0, w_we_fall, w_sclk_fall, w_le_fall, w_sclk_lvl, w_le_lvl};

  // CPU write path: sample data while strobe is low, commit on strobe release
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_hold  <= 8'h00;
      r_td_q  <= 8'h00;
      r_tc_q  <= 8'h00;
      r_td_wr <= 1'b0;
      r_tc_wr <= 1'b0;
    end else begin
      r_td_wr <= 1'b0;
      r_tc_wr <= 1'b0;
      if (!w_we_lvl) begin
        r_hold <= cpu_data;
      end
      if (w_we_rise) begin
        // TD has priority when both selects are set
        if (td_addr) begin
          r_td_q  <= r_hold;
          r_td_wr <= 1'b1;
        end else if (tc_addr) begin
          r_tc_q  <= r_hold;
          r_tc_wr <= 1'b1;
        end
      end
    end
  end

  // Pi FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Pi FSM next state: a load-enable edge restarts from any state
  always_comb begin
    w_state_nxt = r_state;
    if (w_le_rise) begin
      w_state_nxt = LOAD;
    end else begin
      case (r_state)
        IDLE:    w_state_nxt = IDLE;
        LOAD:    w_state_nxt = SHIFT;
        SHIFT: begin
          if (w_sclk_rise && (r_cnt == 3'd7)) begin
            w_state_nxt = IDLE;
          end else begin
            w_state_nxt = SHIFT;
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // Pi FSM outputs: shift register / counter next values and next pi_sdo
  always_comb begin
    w_shift_nxt = r_shift;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      LOAD: begin
        // Reads the registered value, i.e. before any same-cycle commit
        if (pi_sel == PI_SEL_TC) begin
          w_shift_nxt = r_tc_q;
        end else begin
          w_shift_nxt = r_td_q;
        end
        w_cnt_nxt = 3'd0;
      end
      SHIFT: begin
        if (w_sclk_rise) begin
          w_shift_nxt = tipi_shl(r_shift);
          w_cnt_nxt   = r_cnt + 3'd1;
        end else begin
          w_shift_nxt = r_shift;
          w_cnt_nxt   = r_cnt;
        end
      end
      default: begin
        w_shift_nxt = r_shift;
        w_cnt_nxt   = r_cnt;
      end
    endcase
    if (w_state_nxt == SHIFT) begin
      w_sdo_nxt = w_shift_nxt[TIPI_REG_W-1];
    end else begin
      w_sdo_nxt = 1'b0;
    end
  end

  // Pi datapath registers, pi_sdo registered so it tracks bit 7 in SHIFT
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_shift <= 8'h00;
      r_cnt   <= 3'd0;
      r_sdo   <= 1'b0;
    end else begin
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sdo   <= w_sdo_nxt;
    end
  end

  assign td_q   = r_td_q;
  assign tc_q   = r_tc_q;
  assign td_wr  = r_td_wr;
  assign tc_wr  = r_tc_wr;
  assign pi_sdo = r_sdo;

endmodule

// File: tb/tb_tipi_wreg_shift.sv
// Self-checking bench for tipi_wreg_shift: table-driven CPU writes with a
// commit-pulse scoreboard, plus hand-written shift, restart, reset and
// latency sequences.
module tb_tipi_wreg_shift;
  import tipi_pkg::*;

`ifdef TIPI_WR_SYNC_EN
  localparam int LAT_EXP = 3;
`else
  localparam int LAT_EXP = 2;
`endif

  logic       clk;
  logic       reset_n;
  logic       cpu_we_n;
  logic       td_addr;
  logic       tc_addr;
  logic [7:0] cpu_data;
  logic       pi_sclk;
  logic       pi_le;
  logic       pi_sel;
  logic       pi_sdo;
  logic [7:0] td_q;
  logic [7:0] tc_q;
  logic       td_wr;
  logic       tc_wr;

  int total = 0;
  int bad   = 0;
  int tdw_cnt = 0;
  int tcw_cnt = 0;

  typedef struct {
    logic       is_td;
    logic [7:0] val;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic       ta;
    logic       tc;
    logic [7:0] data;
    logic [7:0] exp_td;
    logic [7:0] exp_tc;
    int         exp_tdw;
    int         exp_tcw;
  } vec_t;
  vec_t vecs[7];

  tipi_wreg_shift dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cpu_we_n (cpu_we_n),
    .td_addr  (td_addr),
    .tc_addr  (tc_addr),
    .cpu_data (cpu_data),
    .pi_sclk  (pi_sclk),
    .pi_le    (pi_le),
    .pi_sel   (pi_sel),
    .pi_sdo   (pi_sdo),
    .td_q     (td_q),
    .tc_q     (tc_q),
    .td_wr    (td_wr),
    .tc_wr    (tc_wr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every commit pulse pops one expected commit
  always @(negedge clk) begin
    exp_t e;
    if (reset_n) begin
      if (td_wr) tdw_cnt++;
      if (tc_wr) tcw_cnt++;
      if (td_wr || tc_wr) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL sb_unexpected actual=td_wr%0b/tc_wr%0b required=no_pulse", td_wr, tc_wr);
        end else begin
          e = sb.pop_front();
          if (e.is_td) begin
            if (!(td_wr && !tc_wr && td_q == e.val)) begin
              bad++;
              $display("FAIL sb_td actual=wr%0b%0b q=0x%0h required=td 0x%0h", td_wr, tc_wr, td_q, e.val);
            end
          end else begin
            if (!(tc_wr && !td_wr && tc_q == e.val)) begin
              bad++;
              $display("FAIL sb_tc actual=wr%0b%0b q=0x%0h required=tc 0x%0h", td_wr, tc_wr, tc_q, e.val);
            end
          end
        end
      end
    end
  end

  task automatic do_write(input logic ta, input logic tc, input logic [7:0] d, output int lat);
    @(negedge clk);
    td_addr  = ta;
    tc_addr  = tc;
    cpu_data = d;
    cpu_we_n = 1'b0;
    repeat (4) @(negedge clk);
    cpu_we_n = 1'b1;
    lat = -1;
    @(posedge clk);
    for (int n = 1; n <= 10; n++) begin
      @(posedge clk);
      #1;
      if ((td_wr || tc_wr) && lat < 0) lat = n;
    end
    @(negedge clk);
    td_addr = 1'b0;
    tc_addr = 1'b0;
  endtask

  task automatic le_pulse();
    @(negedge clk);
    pi_le = 1'b1;
    repeat (4) @(negedge clk);
    pi_le = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic sclk_edge();
    @(negedge clk);
    pi_sclk = 1'b1;
    repeat (4) @(negedge clk);
    pi_sclk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    int         lat;
    int         tdw0;
    int         tcw0;
    logic [7:0] pat;

    vecs[0] = '{1'b1, 1'b0, 8'hA5, 8'hA5, 8'h00, 1, 0};
    vecs[1] = '{1'b1, 1'b1, 8'h3C, 8'h3C, 8'h00, 1, 0};
    vecs[2] = '{1'b0, 1'b1, 8'h81, 8'h3C, 8'h81, 0, 1};
    vecs[3] = '{1'b0, 1'b0, 8'hFF, 8'h3C, 8'h81, 0, 0};
    vecs[4] = '{1'b0, 1'b1, 8'h5A, 8'h3C, 8'h5A, 0, 1};
    vecs[5] = '{1'b1, 1'b1, 8'hF0, 8'hF0, 8'h5A, 1, 0};
    vecs[6] = '{1'b0, 1'b1, 8'h81, 8'hF0, 8'h81, 0, 1};

    reset_n  = 1'b0;
    cpu_we_n = 1'b1;
    td_addr  = 1'b0;
    tc_addr  = 1'b0;
    cpu_data = 8'h00;
    pi_sclk  = 1'b0;
    pi_le    = 1'b0;
    pi_sel   = 1'b0;
    repeat (3) @(negedge clk);

    // Reset state
    chk("rst_td_q", 32'(td_q), 32'h0);
    chk("rst_tc_q", 32'(tc_q), 32'h0);
    chk("rst_wr", 32'({td_wr, tc_wr}), 32'h0);
    chk("rst_sdo", 32'(pi_sdo), 32'h0);
    chk("rst_state", 32'(dut.r_state), 32'(IDLE));
    reset_n = 1'b1;
    repeat (3) @(negedge clk);

    // Table-driven writes
    for (int i = 0; i < 7; i++) begin
      exp_t e;
      tdw0 = tdw_cnt;
      tcw0 = tcw_cnt;
      if (vecs[i].exp_tdw == 1) begin
        e.is_td = 1'b1; e.val = vecs[i].data; sb.push_back(e);
      end else if (vecs[i].exp_tcw == 1) begin
        e.is_td = 1'b0; e.val = vecs[i].data; sb.push_back(e);
      end
      do_write(vecs[i].ta, vecs[i].tc, vecs[i].data, lat);
      chk($sformatf("vec%0d_td_q", i), 32'(td_q), 32'(vecs[i].exp_td));
      chk($sformatf("vec%0d_tc_q", i), 32'(tc_q), 32'(vecs[i].exp_tc));
      chk($sformatf("vec%0d_td_wr_cycles", i), 32'(tdw_cnt - tdw0), 32'(vecs[i].exp_tdw));
      chk($sformatf("vec%0d_tc_wr_cycles", i), 32'(tcw_cnt - tcw0), 32'(vecs[i].exp_tcw));
    end

    // Shift out TC=0x81
    pi_sel = PI_SEL_TC;
    pat = 8'h81;
    le_pulse();
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("shift_bit%0d", b), 32'(pi_sdo), 32'(pat[7-b]));
      sclk_edge();
    end
    chk("shift_end_sdo", 32'(pi_sdo), 32'h0);
    chk("shift_end_state", 32'(dut.r_state), 32'(IDLE));
    sclk_edge();
    chk("idle_sclk_sdo", 32'(pi_sdo), 32'h0);
    chk("idle_sclk_state", 32'(dut.r_state), 32'(IDLE));

    // Restart mid-byte from TD=0xF0
    pi_sel = PI_SEL_TD;
    pat = 8'hF0;
    le_pulse();
    for (int b = 0; b < 3; b++) begin
      chk($sformatf("pre_restart_bit%0d", b), 32'(pi_sdo), 32'(pat[7-b]));
      sclk_edge();
    end
    le_pulse();
    for (int b = 0; b < 8; b++) begin
      chk($sformatf("restart_bit%0d", b), 32'(pi_sdo), 32'(pat[7-b]));
      sclk_edge();
    end
    chk("restart_end_state", 32'(dut.r_state), 32'(IDLE));

    // Reset mid-shift
    le_pulse();
    sclk_edge();
    sclk_edge();
    chk("pre_reset_sdo", 32'(pi_sdo), 32'h1);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("mid_reset_sdo", 32'(pi_sdo), 32'h0);
    chk("mid_reset_td_q", 32'(td_q), 32'h0);
    chk("mid_reset_tc_q", 32'(tc_q), 32'h0);
    chk("mid_reset_wr", 32'({td_wr, tc_wr}), 32'h0);
    chk("mid_reset_state", 32'(dut.r_state), 32'(IDLE));
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    tdw0 = tdw_cnt;
    tcw0 = tcw_cnt;
    repeat (8) @(negedge clk);
    chk("post_reset_no_wr", 32'((tdw_cnt - tdw0) + (tcw_cnt - tcw0)), 32'h0);
    chk("post_reset_state", 32'(dut.r_state), 32'(IDLE));
    sclk_edge();
    chk("post_reset_sclk_sdo", 32'(pi_sdo), 32'h0);

    // Strobe-release to commit latency
    begin
      exp_t e;
      e.is_td = 1'b1; e.val = 8'h96; sb.push_back(e);
    end
    do_write(1'b1, 1'b0, 8'h96, lat);
    chk("latency", 32'(lat), 32'(LAT_EXP));
    chk("latency_td_q", 32'(td_q), 32'h96);

    chk("sb_empty", 32'(sb.size()), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
